alu_mux_arbiter: RTL



---
 rtl/alu_mux_pkg.sv | 25 ++
 rtl/alu_mux_arbiter_if.sv | 46 ++++
 rtl/alu_mux_arbiter_alu_core.sv | 57 +++++
 rtl/alu_mux_arbiter_mux2.sv | 14 +
 rtl/alu_mux_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/alu_mux_pkg.sv
// rtl/alu_mux_pkg.sv - shared widths, opcode and FSM state types for the ALU arbiter
package alu_mux_pkg;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;
    localparam int SHW   = $clog2(WIDTH);

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mux_arbiter_if.sv
// rtl/alu_mux_arbiter_if.sv - requester/result bus between the two operand sources and the shared ALU arbiter
// Signals: a_*/b_* request, opcode, operands and grant per requester; sel operand mux select;
// res_valid/res_ready/res_id/res_data result handshake; busy FSM not idle.
// Macro ALU_FLAGS_EN adds res_zero and res_carry.
// Modports: master = requesters and result consumer, slave = arbiter.
interface alu_mux_arbiter_if;
    import alu_mux_pkg::*;

    logic             a_req;
    logic [OPW-1:0]   a_op;
    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] a_y;
    logic             a_gnt;
    logic             b_req;
    logic [OPW-1:0]   b_op;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] b_y;
    logic             b_gnt;
    logic             sel;
    logic             res_valid;
    logic             res_id;
    logic [WIDTH-1:0] res_data;
    logic             res_ready;
    logic             busy;
`ifdef ALU_FLAGS_EN
    logic             res_zero;
    logic             res_carry;
`endif

    modport master (
        output a_req, a_op, a_x, a_y, b_req, b_op, b_x, b_y, res_ready,
        input  a_gnt, b_gnt, sel, res_valid, res_id, res_data, busy
`ifdef ALU_FLAGS_EN
        , input res_zero, res_carry
`endif
    );

    modport slave (
        input  a_req, a_op, a_x, a_y, b_req, b_op, b_x, b_y, res_ready,
        output a_gnt, b_gnt, sel, res_valid, res_id, res_data, busy
`ifdef ALU_FLAGS_EN
        , output res_zero, res_carry
`endif
    );

endinterface

// File: rtl/alu_mux_arbiter_alu_core.sv
// rtl/alu_mux_arbiter_alu_core.sv - combinational 8-op ALU
// Ports: op opcode, x/y operands, result; with ALU_FLAGS_EN also carry (ADD carry / SUB borrow).
module alu_core
    import alu_mux_pkg::*;
(
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry
`endif
);

`ifdef ALU_FLAGS_EN
    // One extra bit holds the ADD carry; for SUB it is the borrow (set when x < y unsigned).
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    assign sum_w  = {1'b0, x} + {1'b0, y};
    assign diff_w = {1'b0, x} - {1'b0, y};
`else
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    assign sum_w  = x + y;
    assign diff_w = x - y;
`endif

    always_comb begin
        result = '0;
`ifdef ALU_FLAGS_EN
        carry  = 1'b0;
`endif
        case (op)
            OP_ADD: begin
                result = sum_w[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
                carry  = sum_w[WIDTH];
`endif
            end
            OP_SUB: begin
                result = diff_w[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
                carry  = diff_w[WIDTH];
`endif
            end
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SHL:  result = x << y[SHW-1:0];
            OP_SHR:  result = x >> y[SHW-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mux_arbiter_mux2.sv
// rtl/alu_mux_arbiter_mux2.sv - 2:1 operand mux
// Ports: sel (0 = d0, 1 = d1), d0, d1 data inputs, y selected output.
module operand_mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/alu_mux_arbiter.sv
// rtl/alu_mux_arbiter.sv - round-robin arbiter sharing one ALU between requesters A and B
// Ports: clk, rst (async, active-high), bus (slave modport of alu_mux_arbiter_if).
// Flow: IDLE grants and latches operands, EXEC computes and registers the result,
// DONE holds it until res_ready. Macro ALU_FLAGS_EN adds registered res_zero/res_carry.
module alu_mux_arbiter
    import alu_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_mux_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             sel_q, sel_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
`ifdef ALU_FLAGS_EN
    logic             res_zero_q, res_zero_d;
    logic             res_carry_q, res_carry_d;
    logic             alu_carry;
`endif

    logic             grant;
    logic             winner;
    logic [OPW-1:0]   mux_op;
    logic [WIDTH-1:0] mux_x;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] alu_result;

    // The muxes follow sel_d so the winner's operands are captured on the grant edge itself.
    operand_mux2 #(.W(OPW))   u_mux_op (.sel(sel_d), .d0(bus.a_op), .d1(bus.b_op), .y(mux_op));
    operand_mux2 #(.W(WIDTH)) u_mux_x  (.sel(sel_d), .d0(bus.a_x),  .d1(bus.b_x),  .y(mux_x));
    operand_mux2 #(.W(WIDTH)) u_mux_y  (.sel(sel_d), .d0(bus.a_y),  .d1(bus.b_y),  .y(mux_y));

    alu_core u_alu (
        .op     (op_q),
        .x      (x_q),
        .y      (y_q),
        .result (alu_result)
`ifdef ALU_FLAGS_EN
        ,
        .carry  (alu_carry)
`endif
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_data_d   = res_data_q;
`ifdef ALU_FLAGS_EN
        res_zero_d   = res_zero_q;
        res_carry_d  = res_carry_q;
`endif
        grant        = 1'b0;
        // On a tie the requester that did not win last time goes next.
        winner       = (bus.a_req && bus.b_req) ? ~last_grant_q : bus.b_req;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant        = 1'b1;
                    sel_d        = winner;
                    op_d         = mux_op;
                    x_d          = mux_x;
                    y_d          = mux_y;
                    last_grant_d = winner;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = alu_result;
                res_id_d    = sel_q;
                res_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
                res_zero_d  = (alu_result == '0);
                res_carry_d = alu_carry;
`endif
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_data_q   <= '0;
`ifdef ALU_FLAGS_EN
            res_zero_q   <= 1'b0;
            res_carry_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_data_q   <= res_data_d;
`ifdef ALU_FLAGS_EN
            res_zero_q   <= res_zero_d;
            res_carry_q  <= res_carry_d;
`endif
        end
    end

    // gnt marks the cycle whose closing edge captures the operands, so the requester
    // may drop req right after it; it lasts one cycle because the FSM leaves IDLE.
    assign bus.a_gnt     = grant & ~winner;
    assign bus.b_gnt     = grant &  winner;
    assign bus.sel       = sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef ALU_FLAGS_EN
    assign bus.res_zero  = res_zero_q;
    assign bus.res_carry = res_carry_q;
`endif

endmodule
